// File: rtl/nasti_cmd_sequencer_pkg.sv
// Shared NASTI definitions used by the command sequencer and the frontend:
// burst encodings, response codes, sequencer states and FIFO word widths.
package nasti_cmd_sequencer_pkg;

  // AXI burst types; the reserved encoding 2'b11 is handled like INCR.
  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  // Write response codes.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2
  } seq_state_e;

  // len[7:0] + size[2:0] + burst[1:0] carried after id/addr in an AR/AW word.
  localparam int AX_CTRL_WIDTH = 13;

  // AR/AW FIFO word: {id, addr, len, size, burst}.
  function automatic int ax_width(input int id_w, input int addr_w);
    return id_w + addr_w + AX_CTRL_WIDTH;
  endfunction

  // W FIFO word: {data, strb}.
  function automatic int w_width(input int data_w);
    return data_w + data_w / 8;
  endfunction

  // B FIFO word: {id, resp}.
  function automatic int b_width(input int id_w);
    return id_w + 2;
  endfunction

endpackage

// File: rtl/nasti_cmd_sequencer_addr_gen.sv
// Next-beat address calculator for FIXED, INCR and WRAP bursts.
module nasti_addr_gen
  import nasti_cmd_sequencer_pkg::*;
#(
  parameter int C_ADDR_WIDTH = 32
) (
  input  logic [C_ADDR_WIDTH-1:0] addr,
  input  logic [2:0]              size,
  input  logic [7:0]              len,
  input  logic [1:0]              burst,
  output logic [C_ADDR_WIDTH-1:0] next_addr
);

  logic [C_ADDR_WIDTH-1:0] step;
  logic [C_ADDR_WIDTH-1:0] incr_addr;
  logic [C_ADDR_WIDTH-1:0] wrap_mask;

  // Step by one beat; WRAP keeps the upper bits of the aligned window base
  // and lets only the offset inside the (len+1)<<size window advance.
  always_comb begin
    step      = C_ADDR_WIDTH'(1) << size;
    incr_addr = addr + step;
    wrap_mask = ((C_ADDR_WIDTH'(len) + C_ADDR_WIDTH'(1)) << size) - C_ADDR_WIDTH'(1);
    next_addr = incr_addr;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/nasti_cmd_sequencer.sv
// Pulls AXI read/write address commands from FWFT FIFOs, arbitrates them
// round-robin, and expands each burst into per-beat commands for the DDR
// scheduler, consuming write data and producing write responses.
module nasti_cmd_sequencer
  import nasti_cmd_sequencer_pkg::*;
#(
  parameter int C_ID_WIDTH   = 4,
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_DATA_WIDTH = 64
) (
  input  logic                                       core_clk,
  input  logic                                       core_arstn,
  input  logic [ax_width(C_ID_WIDTH, C_ADDR_WIDTH)-1:0] rdata_ar,
  input  logic                                       rempty_ar,
  output logic                                       rinc_ar,
  input  logic [ax_width(C_ID_WIDTH, C_ADDR_WIDTH)-1:0] rdata_aw,
  input  logic                                       rempty_aw,
  output logic                                       rinc_aw,
  input  logic [w_width(C_DATA_WIDTH)-1:0]           rdata_w,
  input  logic                                       rempty_w,
  output logic                                       rinc_w,
  output logic [b_width(C_ID_WIDTH)-1:0]             wdata_b,
  input  logic                                       wfull_b,
  output logic                                       winc_b,
  output logic                                       cmd_valid,
  input  logic                                       cmd_ready,
  output logic                                       cmd_we,
  output logic [C_ADDR_WIDTH-1:0]                    cmd_addr,
  output logic [C_ID_WIDTH-1:0]                      cmd_id,
  output logic                                       cmd_last,
  output logic [C_DATA_WIDTH-1:0]                    cmd_wdata,
  output logic [C_DATA_WIDTH/8-1:0]                  cmd_wstrb
);

  localparam int STRB_WIDTH = C_DATA_WIDTH / 8;

  typedef struct packed {
    logic [C_ID_WIDTH-1:0]   id;
    logic [C_ADDR_WIDTH-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
  } ax_fields_t;

  ax_fields_t ar_fields;
  ax_fields_t aw_fields;
  ax_fields_t sel_fields;

  logic [C_DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0]   w_strb;

  seq_state_e              state_q, state_d;
  logic                    rr_rd_q, rr_rd_d;
  logic [C_ID_WIDTH-1:0]   id_q, id_d;
  logic [C_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]              len_q, len_d;
  logic [2:0]              size_q, size_d;
  logic [1:0]              burst_q, burst_d;
  logic [7:0]              beat_q, beat_d;

  logic                    grant_rd;
  logic                    grant_wr;
  logic                    last_beat;
  logic                    beat_fire;
  logic [C_ADDR_WIDTH-1:0] next_addr;

  assign ar_fields = rdata_ar;
  assign aw_fields = rdata_aw;
  assign w_data    = rdata_w[STRB_WIDTH +: C_DATA_WIDTH];
  assign w_strb    = rdata_w[STRB_WIDTH-1:0];

  // The latched burst fields are stable while a beat is offered, so the
  // command outputs come straight from the flops.
  assign cmd_addr  = addr_q;
  assign cmd_id    = id_q;
  assign wdata_b   = {id_q, RESP_OKAY};
  assign last_beat = (beat_q == len_q);

  // Round-robin arbitration: rr_rd_q means read has priority on contention.
  always_comb begin
    grant_rd   = !rempty_ar && (rempty_aw || rr_rd_q);
    grant_wr   = !rempty_aw && (rempty_ar || !rr_rd_q);
    sel_fields = grant_rd ? ar_fields : aw_fields;
  end

  nasti_addr_gen #(
    .C_ADDR_WIDTH(C_ADDR_WIDTH)
  ) u_addr_gen (
    .addr      (addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  // Next-state and output logic: grant in IDLE, then one command per beat.
  always_comb begin
    state_d   = state_q;
    rr_rd_d   = rr_rd_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    beat_d    = beat_q;
    rinc_ar   = 1'b0;
    rinc_aw   = 1'b0;
    rinc_w    = 1'b0;
    winc_b    = 1'b0;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_last  = 1'b0;
    cmd_wdata = '0;
    cmd_wstrb = '0;
    beat_fire = 1'b0;

    case (state_q)
      IDLE: begin
        // Pops are suppressed while reset is asserted so no FIFO word is lost.
        if (core_arstn && (grant_rd || grant_wr)) begin
          rinc_ar = grant_rd;
          rinc_aw = grant_wr;
          id_d    = sel_fields.id;
          addr_d  = sel_fields.addr;
          len_d   = sel_fields.len;
          size_d  = sel_fields.size;
          burst_d = sel_fields.burst;
          beat_d  = 8'd0;
          rr_rd_d = grant_wr;
          state_d = grant_rd ? RD_BURST : WR_BURST;
        end
      end
      RD_BURST: begin
        cmd_valid = 1'b1;
        cmd_last  = last_beat;
        beat_fire = cmd_ready;
      end
      WR_BURST: begin
        cmd_we    = 1'b1;
        cmd_last  = last_beat;
        cmd_wdata = w_data;
        cmd_wstrb = w_strb;
        cmd_valid = !rempty_w && (!last_beat || !wfull_b);
        beat_fire = cmd_valid && cmd_ready;
        rinc_w    = beat_fire;
        winc_b    = beat_fire && last_beat;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (beat_fire) begin
      addr_d = next_addr;
      if (last_beat) begin
        state_d = IDLE;
      end else begin
        beat_d = beat_q + 8'd1;
      end
    end
  end

  // State and latched burst fields with asynchronous active-low reset.
  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) begin
      state_q <= IDLE;
      rr_rd_q <= 1'b1;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_rd_q <= rr_rd_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
    end
  end

endmodule

// File: tb/tb_nasti_cmd_sequencer.sv
// Self-checking bench for nasti_cmd_sequencer: FIFOs are modelled as queues
// and every beat is compared against a burst-level reference model.
module tb_nasti_cmd_sequencer;

  logic        core_clk = 1'b0;
  logic        core_arstn;
  logic [48:0] rdata_ar, rdata_aw;
  logic        rempty_ar, rempty_aw, rinc_ar, rinc_aw;
  logic [71:0] rdata_w;
  logic        rempty_w, rinc_w;
  logic [5:0]  wdata_b;
  logic        wfull_b, winc_b;
  logic        cmd_valid, cmd_ready, cmd_we, cmd_last;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_id;
  logic [63:0] cmd_wdata;
  logic [7:0]  cmd_wstrb;

  nasti_cmd_sequencer dut (
    .core_clk(core_clk), .core_arstn(core_arstn),
    .rdata_ar(rdata_ar), .rempty_ar(rempty_ar), .rinc_ar(rinc_ar),
    .rdata_aw(rdata_aw), .rempty_aw(rempty_aw), .rinc_aw(rinc_aw),
    .rdata_w(rdata_w), .rempty_w(rempty_w), .rinc_w(rinc_w),
    .wdata_b(wdata_b), .wfull_b(wfull_b), .winc_b(winc_b),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_id(cmd_id), .cmd_last(cmd_last),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb)
  );

  always #5 core_clk = ~core_clk;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ax_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
  } w_t;

  ax_t         ar_q[$];
  ax_t         aw_q[$];
  w_t          w_q[$];
  logic [31:0] exp_addr[$];
  logic [31:0] obs_addr[$];
  int          grant_log[$];

  int          mode;
  bit          rr_read;
  logic [3:0]  cur_id;
  int          bursts_done, rinc_ar_cnt, rinc_w_cnt, winc_b_cnt;
  bit          ready_random, wfull_random;
  logic        wfull_fix;
  int          n_checks, n_pass;

  // Expected beat addresses of a burst, from the AXI address rules.
  function automatic void load_beats(input ax_t a);
    longint unsigned stp, total, base, off, start;
    exp_addr.delete();
    start = longint'(a.addr);
    stp   = 64'd1 << a.size;
    total = (longint'(a.len) + 1) * stp;
    base  = start - (start % total);
    for (int i = 0; i <= int'(a.len); i++) begin
      case (a.burst)
        2'b00:   exp_addr.push_back(a.addr);
        2'b10: begin
          off = (start - base + longint'(i) * stp) % total;
          exp_addr.push_back(32'(base + off));
        end
        default: exp_addr.push_back(32'(start + longint'(i) * stp));
      endcase
    end
  endfunction

  // One clock: drive FIFO views, compare DUT outputs with the model, advance.
  task automatic step();
    logic exp_ar, exp_aw, exp_valid, fire, last;
    rempty_ar = (ar_q.size() == 0);
    rdata_ar  = rempty_ar ? '0 : ar_q[0];
    rempty_aw = (aw_q.size() == 0);
    rdata_aw  = rempty_aw ? '0 : aw_q[0];
    rempty_w  = (w_q.size() == 0);
    rdata_w   = rempty_w ? '0 : w_q[0];
    cmd_ready = ready_random ? ($urandom_range(0, 1) != 0) : 1'b1;
    wfull_b   = wfull_random ? ($urandom_range(0, 3) == 0) : wfull_fix;
    #1;
    if (rinc_ar) rinc_ar_cnt++;
    if (rinc_w)  rinc_w_cnt++;
    if (winc_b)  winc_b_cnt++;
    if (mode == 0) begin
      exp_ar = !rempty_ar && (rempty_aw || rr_read);
      exp_aw = !rempty_aw && (rempty_ar || !rr_read);
      n_checks++; if (rinc_ar !== exp_ar) $display("FAIL idle_rinc_ar: got %b want %b", rinc_ar, exp_ar); else n_pass++;
      n_checks++; if (rinc_aw !== exp_aw) $display("FAIL idle_rinc_aw: got %b want %b", rinc_aw, exp_aw); else n_pass++;
      n_checks++; if (cmd_valid !== 1'b0) $display("FAIL idle_cmd_valid: got %b want 0", cmd_valid); else n_pass++;
      if (exp_ar) begin
        load_beats(ar_q[0]); cur_id = ar_q[0].id; void'(ar_q.pop_front());
        mode = 1; rr_read = 1'b0; grant_log.push_back(1);
      end else if (exp_aw) begin
        load_beats(aw_q[0]); cur_id = aw_q[0].id; void'(aw_q.pop_front());
        mode = 2; rr_read = 1'b1; grant_log.push_back(2);
      end
    end else begin
      last      = (exp_addr.size() == 1);
      exp_valid = (mode == 1) ? 1'b1 : ((w_q.size() != 0) && (!last || !wfull_b));
      fire      = exp_valid && cmd_ready;
      n_checks++; if ({rinc_ar, rinc_aw} !== 2'b00) $display("FAIL busy_rinc_ax: got %b want 00", {rinc_ar, rinc_aw}); else n_pass++;
      n_checks++; if (cmd_valid !== exp_valid) $display("FAIL cmd_valid: got %b want %b", cmd_valid, exp_valid); else n_pass++;
      n_checks++; if (rinc_w !== (mode == 2 && fire)) $display("FAIL rinc_w: got %b want %b", rinc_w, (mode == 2 && fire)); else n_pass++;
      n_checks++; if (winc_b !== (mode == 2 && fire && last)) $display("FAIL winc_b: got %b want %b", winc_b, (mode == 2 && fire && last)); else n_pass++;
      if (exp_valid) begin
        n_checks++; if (cmd_addr !== exp_addr[0]) $display("FAIL cmd_addr: got %h want %h", cmd_addr, exp_addr[0]); else n_pass++;
        n_checks++; if (cmd_id !== cur_id) $display("FAIL cmd_id: got %h want %h", cmd_id, cur_id); else n_pass++;
        n_checks++; if (cmd_we !== (mode == 2)) $display("FAIL cmd_we: got %b want %b", cmd_we, (mode == 2)); else n_pass++;
        n_checks++; if (cmd_last !== last) $display("FAIL cmd_last: got %b want %b", cmd_last, last); else n_pass++;
        if (mode == 2) begin
          n_checks++; if ({cmd_wdata, cmd_wstrb} !== w_q[0]) $display("FAIL cmd_wdata: got %h want %h", {cmd_wdata, cmd_wstrb}, w_q[0]); else n_pass++;
        end else begin
          n_checks++; if (cmd_wstrb !== 8'h00) $display("FAIL rd_wstrb: got %h want 00", cmd_wstrb); else n_pass++;
        end
      end
      if (mode == 2 && fire && last) begin
        n_checks++; if (wdata_b !== {cur_id, 2'b00}) $display("FAIL wdata_b: got %h want %h", wdata_b, {cur_id, 2'b00}); else n_pass++;
      end
      if (fire) begin
        obs_addr.push_back(cmd_addr);
        void'(exp_addr.pop_front());
        if (mode == 2) void'(w_q.pop_front());
        if (last) begin
          mode = 0;
          bursts_done++;
        end
      end
    end
    @(posedge core_clk);
    @(negedge core_clk);
  endtask

  task automatic run_bursts(input int n, input int budget);
    int start = bursts_done;
    int cyc   = 0;
    while ((bursts_done - start) < n && cyc < budget) begin
      step();
      cyc++;
    end
    n_checks++;
    if ((bursts_done - start) < n) $display("FAIL burst_timeout: got %0d bursts want %0d", bursts_done - start, n);
    else n_pass++;
  endtask

  task automatic model_reset();
    ar_q.delete(); aw_q.delete(); w_q.delete(); exp_addr.delete();
    mode = 0; rr_read = 1'b1;
  endtask

  task automatic do_reset();
    core_arstn = 1'b0;
    model_reset();
    rempty_ar = 1'b1; rempty_aw = 1'b1; rempty_w = 1'b1;
    repeat (2) @(negedge core_clk);
    core_arstn = 1'b1;
  endtask

  task automatic push_write(input ax_t a);
    w_t w;
    aw_q.push_back(a);
    for (int i = 0; i <= int'(a.len); i++) begin
      w.data = {$urandom, $urandom};
      w.strb = 8'($urandom);
      w_q.push_back(w);
    end
  endtask

  task automatic test_reset();
    core_arstn = 1'b0;
    rdata_ar = {4'd1, 32'h40, 8'd0, 3'd3, 2'b01}; rempty_ar = 1'b0;
    rempty_aw = 1'b1; rempty_w = 1'b1; cmd_ready = 1'b1; wfull_b = 1'b0;
    #1;
    n_checks++; if (rinc_ar !== 1'b0) $display("FAIL reset_rinc_ar: got %b want 0", rinc_ar); else n_pass++;
    n_checks++; if (cmd_valid !== 1'b0) $display("FAIL reset_cmd_valid: got %b want 0", cmd_valid); else n_pass++;
    n_checks++; if ({rinc_aw, rinc_w, winc_b} !== 3'b000) $display("FAIL reset_pulses: got %b want 000", {rinc_aw, rinc_w, winc_b}); else n_pass++;
    do_reset();
    repeat (2) step();
  endtask

  task automatic test_single_read();
    logic [31:0] want [4] = '{32'h100, 32'h108, 32'h110, 32'h118};
    obs_addr.delete(); rinc_ar_cnt = 0;
    ar_q.push_back({4'd3, 32'h100, 8'd3, 3'd3, 2'b01});
    run_bursts(1, 40);
    n_checks++; if (obs_addr.size() != 4) $display("FAIL read_beats: got %0d want 4", obs_addr.size()); else n_pass++;
    for (int i = 0; i < 4 && i < obs_addr.size(); i++) begin
      n_checks++; if (obs_addr[i] !== want[i]) $display("FAIL read_addr%0d: got %h want %h", i, obs_addr[i], want[i]); else n_pass++;
    end
    n_checks++; if (rinc_ar_cnt != 1) $display("FAIL read_rinc_ar_count: got %0d want 1", rinc_ar_cnt); else n_pass++;
    step();
  endtask

  task automatic test_write_backpressure();
    w_t w;
    obs_addr.delete(); rinc_w_cnt = 0; winc_b_cnt = 0;
    aw_q.push_back({4'd5, 32'h200, 8'd1, 3'd3, 2'b01});
    repeat (5) step();
    n_checks++; if (obs_addr.size() != 0) $display("FAIL wr_early_beat: got %0d beats want 0", obs_addr.size()); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      w.data = {$urandom, $urandom}; w.strb = 8'($urandom);
      w_q.push_back(w);
    end
    run_bursts(1, 20);
    n_checks++; if (rinc_w_cnt != 2) $display("FAIL wr_rinc_w_count: got %0d want 2", rinc_w_cnt); else n_pass++;
    n_checks++; if (winc_b_cnt != 1) $display("FAIL wr_winc_b_count: got %0d want 1", winc_b_cnt); else n_pass++;
    step();
  endtask

  task automatic test_contention();
    int want [4] = '{1, 2, 1, 2};
    do_reset();
    grant_log.delete();
    for (int r = 0; r < 2; r++) begin
      ar_q.push_back({4'($urandom), 32'($urandom) & 32'hFFFF_FFF8, 8'd2, 3'd3, 2'b01});
      push_write({4'($urandom), 32'($urandom) & 32'hFFFF_FFF8, 8'd1, 3'd3, 2'b01});
      run_bursts(2, 60);
    end
    n_checks++; if (grant_log.size() != 4) $display("FAIL rr_grants: got %0d want 4", grant_log.size()); else n_pass++;
    for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
      n_checks++; if (grant_log[i] != want[i]) $display("FAIL rr_order%0d: got %0d want %0d", i, grant_log[i], want[i]); else n_pass++;
    end
    step();
  endtask

  task automatic test_wrap();
    logic [31:0] want [4] = '{32'h38, 32'h20, 32'h28, 32'h30};
    obs_addr.delete();
    ar_q.push_back({4'd1, 32'h38, 8'd3, 3'd3, 2'b10});
    run_bursts(1, 40);
    n_checks++; if (obs_addr.size() != 4) $display("FAIL wrap_beats: got %0d want 4", obs_addr.size()); else n_pass++;
    for (int i = 0; i < 4 && i < obs_addr.size(); i++) begin
      n_checks++; if (obs_addr[i] !== want[i]) $display("FAIL wrap_addr%0d: got %h want %h", i, obs_addr[i], want[i]); else n_pass++;
    end
    step();
  endtask

  task automatic test_b_full();
    int start;
    rinc_w_cnt = 0; winc_b_cnt = 0; wfull_fix = 1'b1;
    start = bursts_done;
    push_write({4'd9, 32'h300, 8'd1, 3'd2, 2'b01});
    repeat (6) step();
    n_checks++; if (rinc_w_cnt != 1) $display("FAIL bfull_rinc_w: got %0d want 1", rinc_w_cnt); else n_pass++;
    n_checks++; if (winc_b_cnt != 0 || bursts_done != start) $display("FAIL bfull_stall: got winc_b %0d want 0", winc_b_cnt); else n_pass++;
    wfull_fix = 1'b0;
    run_bursts(1, 10);
    n_checks++; if (winc_b_cnt != 1) $display("FAIL bfull_winc_b: got %0d want 1", winc_b_cnt); else n_pass++;
    step();
  endtask

  task automatic test_reset_mid_burst();
    winc_b_cnt = 0;
    push_write({4'd6, 32'h400, 8'd3, 3'd3, 2'b01});
    repeat (3) step();
    rempty_w = (w_q.size() == 0); rdata_w = rempty_w ? '0 : w_q[0];
    cmd_ready = 1'b1; wfull_b = 1'b0;
    #1;
    n_checks++; if (cmd_valid !== 1'b1 || cmd_addr !== 32'h410) $display("FAIL midrst_beat2: got valid %b addr %h want 1 410", cmd_valid, cmd_addr); else n_pass++;
    core_arstn = 1'b0;
    #1;
    n_checks++; if (cmd_valid !== 1'b0) $display("FAIL midrst_cmd_valid: got %b want 0", cmd_valid); else n_pass++;
    n_checks++; if ({rinc_w, winc_b} !== 2'b00) $display("FAIL midrst_pulses: got %b want 00", {rinc_w, winc_b}); else n_pass++;
    model_reset();
    @(negedge core_clk);
    core_arstn = 1'b1;
    repeat (3) step();
    ar_q.push_back({4'd2, 32'h80, 8'd0, 3'd3, 2'b00});
    run_bursts(1, 10);
    n_checks++; if (winc_b_cnt != 0) $display("FAIL midrst_winc_b: got %0d want 0", winc_b_cnt); else n_pass++;
    step();
  endtask

  task automatic test_random();
    ax_t a;
    int  lens [4] = '{1, 3, 7, 15};
    ready_random = 1'b1; wfull_random = 1'b1;
    for (int t = 0; t < 24; t++) begin
      a.id    = 4'($urandom);
      a.size  = 3'($urandom_range(0, 3));
      a.burst = 2'($urandom);
      a.len   = (a.burst == 2'b10) ? 8'(lens[$urandom_range(0, 3)]) : 8'($urandom_range(0, 7));
      a.addr  = 32'($urandom) & ~((32'd1 << a.size) - 32'd1);
      if ($urandom_range(0, 1) == 0) ar_q.push_back(a);
      else push_write(a);
    end
    run_bursts(24, 4000);
    ready_random = 1'b0; wfull_random = 1'b0;
    step();
  endtask

  initial begin
    n_checks = 0; n_pass = 0; bursts_done = 0;
    rinc_ar_cnt = 0; rinc_w_cnt = 0; winc_b_cnt = 0;
    ready_random = 1'b0; wfull_random = 1'b0; wfull_fix = 1'b0;
    core_arstn = 1'b0; cmd_ready = 1'b0; wfull_b = 1'b0;
    rdata_ar = '0; rdata_aw = '0; rdata_w = '0;
    rempty_ar = 1'b1; rempty_aw = 1'b1; rempty_w = 1'b1;
    model_reset();
    @(negedge core_clk);
    test_reset();
    test_single_read();
    test_write_backpressure();
    test_contention();
    test_wrap();
    test_b_full();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish before 1000000ns");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
